// File: rtl/pc_sequencer_if.sv
// Fetch / redirect / status bundle between the PC sequencer and the
// surrounding core (instruction memory and the execute datapath).
interface pc_sequencer_if;
    // Instruction-memory fetch handshake
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    // Execute-side handshake and redirects
    logic        instr_valid;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        halt;
    logic        resume;
    // Status
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign_trap;
    logic [31:0] retire_count;
    logic [1:0]  state;

    // Sequencer side
    modport master (
        output imem_req, imem_addr, instr_valid, pc, pc_plus4,
               misalign_trap, retire_count, state,
        input  imem_ready, stall, branch_taken, branch_target,
               jump, jump_target, halt, resume
    );

    // Core / memory side
    modport slave (
        input  imem_req, imem_addr, instr_valid, pc, pc_plus4,
               misalign_trap, retire_count, state,
        output imem_ready, stall, branch_taken, branch_target,
               jump, jump_target, halt, resume
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, drives the fetch handshake,
// selects the next PC at retire (jump > branch > pc+4, misaligned
// redirects go to TRAP_VEC) and counts retired instructions.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input logic            clk,
    input logic            reset,
    pc_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        EXEC   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_retire_count;
    logic        r_misalign_trap;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_target;
    logic [31:0] w_next_pc;
    logic        w_redirect;
    logic        w_misaligned;
    logic        w_retire;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_retire   = (r_state == EXEC) && !bus.stall;

    // Next-PC selection: jump wins over branch; a misaligned redirect target diverts to the trap vector
    always_comb begin
        w_redirect        = bus.jump | bus.branch_taken;
        w_redirect_target = bus.jump ? bus.jump_target : bus.branch_target;
        w_misaligned      = w_redirect && (w_redirect_target[1:0] != 2'b00);
        if (w_misaligned) begin
            w_next_pc = TRAP_VEC;
        end else if (w_redirect) begin
            w_next_pc = w_redirect_target;
        end else begin
            w_next_pc = w_pc_plus4;
        end
    end

    // Sequencer FSM with PC, retire counter and trap pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_pc            <= RESET_PC;
            r_retire_count  <= '0;
            r_misalign_trap <= 1'b0;
        end else begin
            // Trap pulse lasts only the cycle right after the retiring instruction
            r_misalign_trap <= w_retire && w_misaligned;
            case (r_state)
                IDLE: begin
                    r_state <= FETCH;
                end
                FETCH: begin
                    if (bus.imem_ready) begin
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    if (!bus.stall) begin
                        r_pc           <= w_next_pc;
                        r_retire_count <= r_retire_count + 32'd1;
                        r_state        <= bus.halt ? HALTED : FETCH;
                    end
                end
                HALTED: begin
                    if (bus.resume) begin
                        r_state <= FETCH;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Handshake outputs decode the registered state so reset drops imem_req without a clock edge
    assign bus.imem_req      = (r_state == FETCH);
    assign bus.instr_valid   = (r_state == EXEC);
    assign bus.imem_addr     = r_pc;
    assign bus.pc            = r_pc;
    assign bus.pc_plus4      = w_pc_plus4;
    assign bus.misalign_trap = r_misalign_trap;
    assign bus.retire_count  = r_retire_count;
    assign bus.state         = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios followed by random stimulus,
// every cycle compared against a cycle-level behavioural model.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_EXEC  = 2;
    localparam int M_HALT  = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_trap;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_PC (RESET_PC),
        .TRAP_VEC (TRAP_VEC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_pc   = RESET_PC;
        m_cnt  = 0;
        m_trap = 1'b0;
    endtask

    task automatic compare_all();
        check("pc",           bus.pc,                    m_pc);
        check("pc_plus4",     bus.pc_plus4,              m_pc + 32'd4);
        check("imem_addr",    bus.imem_addr,             m_pc);
        check("imem_req",     32'(bus.imem_req),         32'(m_mode == M_FETCH));
        check("instr_valid",  32'(bus.instr_valid),      32'(m_mode == M_EXEC));
        check("state",        32'(bus.state),            32'(m_mode));
        check("misalign",     32'(bus.misalign_trap),    32'(m_trap));
        check("retire_count", bus.retire_count,          m_cnt);
    endtask

    task automatic clear_inputs();
        bus.imem_ready    = 1'b0;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        bus.jump          = 1'b0;
        bus.jump_target   = '0;
        bus.halt          = 1'b0;
        bus.resume        = 1'b0;
    endtask

    // One clock: compare at negedge, advance the model on the rising edge,
    // return 1 time unit after the edge so callers can drive new inputs.
    task automatic step();
        int          n_mode;
        logic [31:0] n_pc, n_cnt, tgt;
        logic        n_trap, redir;
        @(negedge clk);
        compare_all();
        n_mode = m_mode; n_pc = m_pc; n_cnt = m_cnt; n_trap = 1'b0;
        if (reset) begin
            n_mode = M_IDLE; n_pc = RESET_PC; n_cnt = 0;
        end else if (m_mode == M_IDLE) begin
            n_mode = M_FETCH;
        end else if (m_mode == M_FETCH) begin
            if (bus.imem_ready) n_mode = M_EXEC;
        end else if (m_mode == M_EXEC) begin
            if (!bus.stall) begin
                n_cnt = m_cnt + 1;
                redir = bus.jump || bus.branch_taken;
                if (bus.jump)              tgt = bus.jump_target;
                else if (bus.branch_taken) tgt = bus.branch_target;
                else                       tgt = m_pc + 4;
                if (redir && (tgt % 4 != 0)) begin
                    n_pc = TRAP_VEC; n_trap = 1'b1;
                end else begin
                    n_pc = tgt;
                end
                n_mode = bus.halt ? M_HALT : M_FETCH;
            end
        end else begin
            if (bus.resume) n_mode = M_FETCH;
        end
        @(posedge clk);
        m_mode = n_mode; m_pc = n_pc; m_cnt = n_cnt; m_trap = n_trap;
        #1;
    endtask

    task automatic go_exec();
        int guard = 0;
        clear_inputs();
        bus.imem_ready = 1'b1;
        bus.resume     = 1'b1;
        while (m_mode != M_EXEC && guard < 10) begin
            step();
            guard++;
        end
        if (m_mode != M_EXEC) check("go_exec_timeout", 32'd1, 32'd0);
        clear_inputs();
    endtask

    task automatic retire(input logic j, input logic [31:0] jt, input logic b,
                          input logic [31:0] bt, input logic h);
        clear_inputs();
        bus.jump = j; bus.jump_target = jt;
        bus.branch_taken = b; bus.branch_target = bt;
        bus.halt = h;
        step();
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        model_reset();

        // Reset held for two cycles
        step();
        step();
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_pc", bus.pc, RESET_PC);

        // Sequential run with memory always ready
        reset = 1'b0;
        bus.imem_ready = 1'b1;
        step();                                  // IDLE -> FETCH
        for (int unsigned i = 0; i < 6; i++) step();
        check("seq_count", bus.retire_count, 32'd3);
        check("seq_pc", bus.imem_addr, 32'h0000_000C);

        // Fetch wait then stall at pc=0x10
        step();                                  // FETCH 0xC -> EXEC
        bus.imem_ready = 1'b0;
        step();                                  // retire -> FETCH 0x10
        for (int unsigned i = 0; i < 3; i++) step();
        check("wait_addr", bus.imem_addr, 32'h0000_0010);
        bus.imem_ready = 1'b1;
        step();
        bus.imem_ready = 1'b0;
        bus.stall = 1'b1;
        step();
        step();
        check("stall_valid", 32'(bus.instr_valid), 32'd1);
        bus.stall = 1'b0;
        step();
        check("stall_pc", bus.imem_addr, 32'h0000_0014);
        check("stall_count", bus.retire_count, 32'd5);

        // Jump beats branch
        go_exec();
        retire(1'b1, 32'h0000_0200, 1'b1, 32'h0000_0300, 1'b0);
        check("prio_addr", bus.imem_addr, 32'h0000_0200);

        // Misaligned jump target traps
        go_exec();
        retire(1'b1, 32'h0000_0202, 1'b0, 32'h0, 1'b0);
        check("trap_pc", bus.pc, TRAP_VEC);
        check("trap_pulse", 32'(bus.misalign_trap), 32'd1);
        step();
        check("trap_clear", 32'(bus.misalign_trap), 32'd0);

        // Halt at pc=0x40, hold, then resume
        go_exec();
        retire(1'b1, 32'h0000_0040, 1'b0, 32'h0, 1'b0);
        go_exec();
        retire(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("halt_state", 32'(bus.state), 32'd3);
        check("halt_pc", bus.pc, 32'h0000_0044);
        for (int unsigned i = 0; i < 5; i++) begin
            bus.imem_ready = 1'($urandom_range(0, 1));
            step();
            check("halt_req", 32'(bus.imem_req), 32'd0);
        end
        bus.resume = 1'b1;
        step();
        bus.resume = 1'b0;
        check("resume_state", 32'(bus.state), 32'd1);
        check("resume_addr", bus.imem_addr, 32'h0000_0044);

        // PC wrap-around
        go_exec();
        retire(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0);
        check("wrap_plus4", bus.pc_plus4, 32'h0000_0000);
        go_exec();
        retire(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("wrap_addr", bus.imem_addr, 32'h0000_0000);

        // Random stimulus against the model
        for (int unsigned i = 0; i < 400; i++) begin
            logic [31:0] jt, bt;
            jt = $urandom;
            bt = $urandom;
            if ($urandom_range(0, 3) != 0) jt[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
            bus.imem_ready    = ($urandom_range(0, 9) < 7);
            bus.stall         = ($urandom_range(0, 9) < 3);
            bus.jump          = ($urandom_range(0, 19) < 3);
            bus.jump_target   = jt;
            bus.branch_taken  = ($urandom_range(0, 9) < 2);
            bus.branch_target = bt;
            bus.halt          = ($urandom_range(0, 19) == 0);
            bus.resume        = ($urandom_range(0, 9) < 3);
            step();
        end

        // Asynchronous reset while a fetch is pending
        begin
            int guard = 0;
            clear_inputs();
            bus.resume = 1'b1;
            while (m_mode != M_FETCH && guard < 10) begin
                step();
                guard++;
            end
            if (m_mode != M_FETCH) check("fetch_timeout", 32'd1, 32'd0);
            bus.resume = 1'b0;
        end
        check("pre_rst_req", 32'(bus.imem_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_req", 32'(bus.imem_req), 32'd0);
        check("async_state", 32'(bus.state), 32'd0);
        check("async_pc", bus.pc, RESET_PC);
        model_reset();
        step();
        reset = 1'b0;
        bus.imem_ready = 1'b1;
        for (int unsigned i = 0; i < 4; i++) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
